// File: rtl/dfff_bank_if.sv
// dfff_bank_if: control/data bundle for the dfff_bank register array (par present when DFFF_BANK_PARITY_EN is defined)
interface dfff_bank_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
);
   logic [CHANNELS-1:0]       en;
   logic [CHANNELS-1:0]       s;
   logic [CHANNELS-1:0]       c;
   logic [CHANNELS*WIDTH-1:0] d;
   logic [CHANNELS*WIDTH-1:0] q;
   logic [CHANNELS*WIDTH-1:0] qbar;
   logic [CHANNELS-1:0]       vld;
   logic [CHANNELS-1:0]       chg;
`ifdef DFFF_BANK_PARITY_EN
   logic [CHANNELS-1:0]       par;
   modport master (output en, s, c, d, input q, qbar, vld, chg, par);
   modport slave  (input en, s, c, d, output q, qbar, vld, chg, par);
`else
   modport master (output en, s, c, d, input q, qbar, vld, chg);
   modport slave  (input en, s, c, d, output q, qbar, vld, chg);
`endif
endinterface

// File: rtl/dfff_bank.sv
// dfff_bank: CHANNELS independent DEPTH-stage load-enabled delay lines with set/clear, fill tracking and change detect; optional parity output under DFFF_BANK_PARITY_EN
module dfff_bank #(
   parameter int                 WIDTH    = 8,
   parameter int                 CHANNELS = 4,
   parameter int                 DEPTH    = 2,
   parameter logic [WIDTH-1:0]   SET_VAL  = {WIDTH{1'b1}}
) (
   input logic         clk,
   input logic         r,
   dfff_bank_if.slave  bus
);
   localparam int               CW   = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]    FULL = CW'(DEPTH);
   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      logic [WIDTH-1:0] st [DEPTH];
      logic [CW-1:0]    cnt;
      logic [WIDTH-1:0] pq;
      logic [WIDTH-1:0] dk;
      assign dk = bus.d[k*WIDTH +: WIDTH];
      // stage and fill-count update; clear beats set beats load, reset beats all
      always_ff @(posedge clk) begin
         if (r || bus.c[k]) begin
            for (int i = 0; i < DEPTH; i++) st[i] <= '0;
            cnt <= '0;
         end else if (bus.s[k]) begin
            for (int i = 0; i < DEPTH; i++) st[i] <= SET_VAL;
            cnt <= FULL;
         end else if (bus.en[k]) begin
            st[0] <= dk;
            for (int i = 1; i < DEPTH; i++) st[i] <= st[i-1];
            cnt <= (cnt == FULL) ? cnt : cnt + 1'b1;
         end
      end
      // previous-edge copy of the last stage for change detect
      always_ff @(posedge clk) begin
         if (r) pq <= '0;
         else pq <= st[DEPTH-1];
      end
      assign bus.q[k*WIDTH +: WIDTH]    = st[DEPTH-1];
      assign bus.qbar[k*WIDTH +: WIDTH] = ~st[DEPTH-1];
      assign bus.vld[k] = (cnt == FULL);
      assign bus.chg[k] = (st[DEPTH-1] != pq);
`ifdef DFFF_BANK_PARITY_EN
      logic             pr;
      logic [WIDTH-1:0] nxt;
      // value the last stage takes on a load, so parity registers alongside it
      if (DEPTH == 1) begin : g_d1
         assign nxt = dk;
      end else begin : g_dn
         assign nxt = st[DEPTH-2];
      end
      // parity register tracking the last stage
      always_ff @(posedge clk) begin
         if (r || bus.c[k]) pr <= 1'b0;
         else if (bus.s[k]) pr <= ^SET_VAL;
         else if (bus.en[k]) pr <= ^nxt;
      end
      assign bus.par[k] = pr;
`endif
   end
endmodule

// File: tb/tb_dfff_bank.sv
// tb_dfff_bank: directed scoreboard bench for dfff_bank (WIDTH=8, CHANNELS=4, DEPTH=2)
module tb_dfff_bank;
   logic clk = 1'b0;
   logic r;
   int   checks = 0;
   int   errors = 0;
   typedef struct {
      int          idx;
      logic [31:0] q;
      logic [3:0]  vld;
      logic [3:0]  chg;
   } exp_t;
   exp_t sb [$];
   dfff_bank_if #(.WIDTH(8), .CHANNELS(4)) bus ();
   dfff_bank #(.WIDTH(8), .CHANNELS(4), .DEPTH(2)) dut (.clk(clk), .r(r), .bus(bus));
   always #5 clk = ~clk;
   int n = 0;
   task automatic step(input logic rr, input logic [3:0] e, input logic [3:0] ss,
                       input logic [3:0] cc, input logic [31:0] dd,
                       input logic [31:0] eq, input logic [3:0] ev, input logic [3:0] ec);
      exp_t x;
      @(negedge clk);
      r = rr; bus.en = e; bus.s = ss; bus.c = cc; bus.d = dd;
      @(posedge clk);
      x.idx = n; x.q = eq; x.vld = ev; x.chg = ec;
      sb.push_back(x);
      n++;
   endtask
   task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, req);
      end
   endtask
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            cmp("q", x.idx, bus.q, x.q);
            cmp("qbar", x.idx, bus.qbar, ~x.q);
            cmp("vld", x.idx, {28'd0, bus.vld}, {28'd0, x.vld});
            cmp("chg", x.idx, {28'd0, bus.chg}, {28'd0, x.chg});
`ifdef DFFF_BANK_PARITY_EN
            cmp("par", x.idx, {28'd0, bus.par},
                {28'd0, ^x.q[31:24], ^x.q[23:16], ^x.q[15:8], ^x.q[7:0]});
`endif
         end
      end
   end
   initial begin
      r = 1'b1; bus.en = '0; bus.s = '0; bus.c = '0; bus.d = '0;
      //    r     en      s       c       d                         exp q                     vld     chg
      step(1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0,                    32'h00000000,            4'b0000, 4'b0000);
      step(1'b0, 4'b0001, 4'b0000, 4'b0000, 32'h000000A5,             32'h00000000,            4'b0000, 4'b0000);
      step(1'b0, 4'b0001, 4'b0000, 4'b0000, 32'h0000003C,             32'h000000A5,            4'b0001, 4'b0001);
      step(1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h000000EE,             32'h000000A5,            4'b0001, 4'b0000);
      step(1'b0, 4'b0000, 4'b0010, 4'b0000, 32'h0,                    32'h0000FFA5,            4'b0011, 4'b0010);
      step(1'b0, 4'b0000, 4'b0010, 4'b0010, 32'h0,                    32'h000000A5,            4'b0001, 4'b0010);
      step(1'b0, 4'b0100, 4'b1000, 4'b0000, 32'h001100DD,             32'hFF0000A5,            4'b1001, 4'b1000);
      step(1'b0, 4'b1101, 4'b0000, 4'b0001, 32'h55220099,             32'hFF110000,            4'b1100, 4'b0101);
      step(1'b0, 4'b0001, 4'b0000, 4'b0000, 32'h00000012,             32'hFF110000,            4'b1100, 4'b0000);
      step(1'b0, 4'b0001, 4'b0000, 4'b0000, 32'h00000034,             32'hFF110012,            4'b1101, 4'b0001);
      step(1'b1, 4'b0001, 4'b0000, 4'b0000, 32'h00000077,             32'h00000000,            4'b0000, 4'b0000);
      step(1'b0, 4'b0001, 4'b0000, 4'b0000, 32'h00000056,             32'h00000000,            4'b0000, 4'b0000);
      step(1'b0, 4'b0001, 4'b0000, 4'b0000, 32'h00000078,             32'h00000056,            4'b0001, 4'b0001);
      step(1'b0, 4'b0001, 4'b0000, 4'b0000, 32'h0000009A,             32'h00000078,            4'b0001, 4'b0001);
      step(1'b0, 4'b0001, 4'b0000, 4'b0000, 32'h0000009A,             32'h0000009A,            4'b0001, 4'b0001);
      step(1'b0, 4'b0001, 4'b0000, 4'b0000, 32'h00000007,             32'h0000009A,            4'b0001, 4'b0000);
      step(1'b0, 4'b0001, 4'b0000, 4'b0000, 32'h00000003,             32'h00000007,            4'b0001, 4'b0001);
      step(1'b0, 4'b0001, 4'b0000, 4'b0000, 32'h00000000,             32'h00000003,            4'b0001, 4'b0001);
      step(1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0,                    32'h00000003,            4'b0001, 4'b0000);
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
